// File: rtl/bcd_msg_serializer_if.sv
// Byte-stream handshake between the message serializer and the UART transmitter.
// The master drives data/valid and the slave answers with ready.
interface bcd_msg_serializer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/bcd_msg_serializer.sv
// Formats a BCD amount (or "PAID") into a fixed-length ASCII line ending in CR LF
// and streams it one byte per valid/ready transfer.
module bcd_msg_serializer #(
  parameter int NDIG     = 3,
  parameter int DP_POS   = 2,
  parameter int LZ_BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*NDIG-1:0]     amount_bcd,
  input  logic                  dispense,
  bcd_msg_serializer_if.master  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int L       = NDIG + ((DP_POS > 0) ? 1 : 0);
  localparam int MSG_LEN = L + 2;
  localparam int IDX_W   = $clog2(MSG_LEN);
  localparam int UNITS   = NDIG - 1 - DP_POS;

  generate
    if (NDIG < 1 || NDIG > 8 || DP_POS < 0 || DP_POS >= NDIG || L < 4) begin : g_badCfg
      $error("bcd_msg_serializer: illegal NDIG/DP_POS combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [IDX_W-1:0]   r_index;
  logic [IDX_W-1:0]   w_indexNext;
  logic [4*NDIG-1:0]  r_amount;
  logic               r_dispense;
  logic               w_load;
  logic               w_xfer;
  logic [7:0]         w_digitChr [NDIG];
  logic [7:0]         w_line     [MSG_LEN];

  // zeroRun stays set while every digit seen so far is zero; the units digit is never blanked
  always_comb begin
    logic [3:0] nib;
    logic       zeroRun;
    w_digitChr = '{default: 8'h00};
    nib        = 4'd0;
    zeroRun    = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      nib = r_amount[4*(NDIG-1-k) +: 4];
      if (nib != 4'd0) zeroRun = 1'b0;
      if (nib > 4'd9)
        w_digitChr[k] = 8'h3F;
      else if (LZ_BLANK != 0 && zeroRun && k < UNITS)
        w_digitChr[k] = 8'h20;
      else
        w_digitChr[k] = 8'h30 + {4'h0, nib};
    end
  end

  always_comb begin
    w_line = '{default: 8'h20};
    if (r_dispense) begin
      w_line[0] = 8'h50;
      w_line[1] = 8'h41;
      w_line[2] = 8'h49;
      w_line[3] = 8'h44;
    end else begin
      for (int k = 0; k < NDIG; k++)
        w_line[k + ((DP_POS > 0 && k >= NDIG - DP_POS) ? 1 : 0)] = w_digitChr[k];
      if (DP_POS > 0) w_line[NDIG - DP_POS] = 8'h2E;
    end
    w_line[L]   = 8'h0D;
    w_line[L+1] = 8'h0A;
  end

  always_comb begin
    w_stateNext = r_state;
    w_indexNext = r_index;
    w_load      = 1'b0;
    w_xfer      = (r_state == SEND) && tx.tx_ready;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_indexNext = '0;
          w_stateNext = SEND;
        end
      end
      SEND: begin
        if (w_xfer) begin
          if (r_index == IDX_W'(MSG_LEN - 1)) begin
            w_indexNext = '0;
            w_stateNext = DONE;
          end else begin
            w_indexNext = r_index + IDX_W'(1);
          end
        end
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_index <= '0;
    end else begin
      r_state <= w_stateNext;
      r_index <= w_indexNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_amount   <= '0;
      r_dispense <= 1'b0;
    end else if (w_load) begin
      r_amount   <= amount_bcd;
      r_dispense <= dispense;
    end
  end

  assign tx.tx_valid = (r_state == SEND);
  assign tx.tx_data  = (r_state == SEND) ? w_line[r_index] : 8'h00;
  assign busy        = (r_state == SEND);
  assign done        = (r_state == DONE);

endmodule

// File: doc/bcd_msg_serializer.md
Name: bcd_msg_serializer

Overview:
- Parametrised successor of the vending-machine amount formatter.
- Snapshots an NDIG-digit BCD amount, or the dispense condition, on a start pulse.
- Builds a fixed-length ASCII line from it: digits with an optional decimal point and leading-zero blanking, or "PAID", always terminated by CR LF.
- Streams the line one byte at a time to the UART transmitter over a valid/ready handshake.

Parameters:
- NDIG, 3, number of BCD digits in amount_bcd (valid range 1..8).
- DP_POS, 2, number of digits to the right of the decimal point (0 = no '.' emitted; must be < NDIG).
- LZ_BLANK, 1, 1 = replace leading zeros with space (8'h20); 0 = print all digits.

Derived constants:
- L = NDIG + (DP_POS>0 ? 1 : 0), the body length.
- MSG_LEN = L + 2.
- Constraint: L >= 4; elaboration fails otherwise.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to format and send a line.
- amount_bcd  input  4*NDIG  BCD amount, most significant digit in the top nibble.
- dispense  input  1  when sampled high with start, the line is "PAID" instead of the amount.
- tx_data  output  8  current ASCII byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  UART transmitter accepts the byte this cycle.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the LF byte is accepted.

Behaviour:
- Reset (async assert, sync release): state IDLE; tx_data=8'h00, tx_valid=0, busy=0, done=0; byte index=0; snapshot registers cleared.
- States: IDLE, SEND, DONE.
- IDLE:
  - When start=1, register amount_bcd and dispense, set index=0, go to SEND.
  - In the next cycle, busy=1, tx_valid=1 and tx_data=byte 0 (latency 1 cycle from start).
- SEND:
  - tx_data is the registered byte [index] and is held stable while tx_valid=1 and tx_ready=0.
  - A transfer occurs when tx_valid and tx_ready are both 1. On a transfer: index++ and tx_data is updated next cycle, so tx_valid stays high for back-to-back transfers at 1 byte/cycle when tx_ready is held high.
  - A transfer of index MSG_LEN-1 (LF) moves to DONE with tx_valid=0.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- start while busy or while in DONE: ignored; no queueing. Snapshot registers are unaffected by input changes during a message.
- Amount body, positions 0..L-1, left to right:
  - Digits from most significant down.
  - '.' (8'h2E) inserted before the last DP_POS digits when DP_POS>0.
  - Digit d in 0..9 maps to 8'h30+d; d in 10..15 maps to '?' (8'h3F).
- Leading-zero blanking (LZ_BLANK=1):
  - A zero digit becomes space if it and every digit to its left is zero, and it lies left of the units digit (digit index DP_POS from the LSD).
  - The units digit and fractional digits are never blanked.
  - An invalid digit stops blanking.
- Dispense body: "PAID" (50 41 49 44) left-justified, then L-4 spaces.
- Bytes L and L+1 are always 8'h0D and 8'h0A.
- Reset asserted mid-message: immediate return to reset values. The partial line is abandoned; no done pulse.
- tx_ready high while tx_valid=0: no effect.

Test Plan:
- Defaults, amount 12'h125, dispense=0, tx_ready=1 always -> tx_valid high 6 consecutive cycles starting 1 cycle after start. Bytes 31 2E 32 35 0D 0A, then done pulse, busy low.
- Defaults, dispense=1, amount 12'h999 -> 50 41 49 44 0D 0A.
- NDIG=4, DP_POS=0, amount 16'h0007 -> 20 20 20 37 0D 0A.
- NDIG=4, DP_POS=0, amount 16'h0000 -> 20 20 20 30 0D 0A.
- Same config with LZ_BLANK=0, amount 16'h0007 -> 30 30 30 37 0D 0A.
- Defaults, amount 12'h1A5 -> 31 2E 3F 35 0D 0A.
- Backpressure, defaults, amount 12'h125: toggle tx_ready with a random pattern and pulse start again mid-message -> tx_data stable while stalled, exactly 6 transfers in order, second start ignored, single done.
- Reset mid-message: assert rst_n=0 after byte 2 is accepted -> tx_valid=0 and busy=0 immediately, no done pulse. A fresh start then produces the full line from byte 0.
